// File: rtl/alu_sweep_checker.sv
// Built-in self-test for the 3-bit-select, 4-bit ALU: sweeps s = 0..7 and checks y against a golden model.
// Optional per-op result log enabled by defining ALU_CHECK_LOG_EN.
module alu_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       cin_in,
  output logic [2:0] alu_s,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  input  logic [3:0] alu_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_err_op,
  input  logic [2:0] log_sel,
  output logic [3:0] log_y
);

  localparam int unsigned DW  = 4;
  localparam int unsigned SW  = 3;
  localparam int unsigned CW  = 4;
  localparam int unsigned NOP = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] alu_s_nxt, first_err_op_nxt;
  logic [DW-1:0] alu_a_nxt, alu_b_nxt, err_count_nxt;
  logic          alu_cin_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [DW-1:0] expected_c;
  logic          mismatch_c;

  // Golden model of the ALU under test; carry-out is discarded.
  always_comb begin
    expected_c = '0;
    case (alu_s)
      3'd0:    expected_c = alu_a + alu_b + DW'(alu_cin);
      3'd1:    expected_c = alu_a + ~alu_b + DW'(alu_cin);
      3'd2:    expected_c = alu_b;
      3'd3:    expected_c = alu_a;
      3'd4:    expected_c = alu_a & alu_b;
      3'd5:    expected_c = alu_a | alu_b;
      3'd6:    expected_c = ~alu_a;
      default: expected_c = alu_a ^ alu_b;
    endcase
  end

  assign mismatch_c = (alu_y != expected_c);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    alu_s_nxt        = alu_s;
    alu_a_nxt        = alu_a;
    alu_b_nxt        = alu_b;
    alu_cin_nxt      = alu_cin;
    err_count_nxt    = err_count;
    first_err_op_nxt = first_err_op;
    pass_nxt         = pass;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt        = S_DRIVE;
          cnt_nxt          = '0;
          alu_s_nxt        = '0;
          alu_a_nxt        = a_in;
          alu_b_nxt        = b_in;
          alu_cin_nxt      = cin_in;
          err_count_nxt    = '0;
          first_err_op_nxt = '0;
          pass_nxt         = 1'b0;
        end
      end
      S_DRIVE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_SAMPLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_SAMPLE: begin
        if (mismatch_c) begin
          err_count_nxt = err_count + DW'(1);
          if (err_count == '0) first_err_op_nxt = alu_s;
        end
        if (alu_s == SW'(NOP - 1)) begin
          state_nxt = S_DONE;
          pass_nxt  = (err_count_nxt == '0);
        end else begin
          alu_s_nxt = alu_s + SW'(1);
          state_nxt = S_DRIVE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_DRIVE) || (state_nxt == S_SAMPLE);
    done_nxt = (state_nxt == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      alu_s        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cin      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_err_op <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      alu_s        <= alu_s_nxt;
      alu_a        <= alu_a_nxt;
      alu_b        <= alu_b_nxt;
      alu_cin      <= alu_cin_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      pass         <= pass_nxt;
      err_count    <= err_count_nxt;
      first_err_op <= first_err_op_nxt;
    end
  end

`ifdef ALU_CHECK_LOG_EN
  // Per-op capture of the observed y; survives a new start, cleared by reset only.
  logic [DW-1:0] log_mem [NOP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NOP; i++) log_mem[i] <= '0;
    end else if (state == S_SAMPLE) begin
      log_mem[alu_s] <= alu_y;
    end
  end

  assign log_y = log_mem[log_sel];
`else
  logic log_sel_unused;

  assign log_sel_unused = ^log_sel;
  assign log_y          = '0;
`endif

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Self-checking bench for alu_sweep_checker: behavioural ALU with fault injection and a result scoreboard.
module tb_alu_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in, b_in;
  logic       cin_in;
  logic [2:0] alu_s;
  logic [3:0] alu_a, alu_b;
  logic       alu_cin;
  logic [3:0] alu_y;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_err_op;
  logic [2:0] log_sel;
  logic [3:0] log_y;

  int n_tests = 0;
  int n_fail  = 0;
  int fault_mode = 0;

  typedef struct packed {
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_err_op;
  } summary_t;

  logic [3:0] y_q[$];
  summary_t   sum_q[$];

  alu_sweep_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_y(alu_y), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_op(first_err_op),
    .log_sel(log_sel), .log_y(log_y)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gold(input logic [2:0] s, input logic [3:0] a,
                                      input logic [3:0] b, input logic c);
    logic [3:0] r;
    case (s)
      3'd0:    r = a + b + 4'(c);
      3'd1:    r = a + ~b + 4'(c);
      3'd2:    r = b;
      3'd3:    r = a;
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      3'd6:    r = ~a;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] inject(input int mode, input logic [2:0] s, input logic [3:0] y);
    logic [3:0] r;
    r = y;
    if (mode == 1 && s == 3'd5) r = 4'h0;
    if (mode == 2 && (s == 3'd2 || s == 3'd6)) r = ~y;
    return r;
  endfunction

  // ALU under test, optionally faulty.
  always_comb alu_y = inject(fault_mode, alu_s, gold(alu_s, alu_a, alu_b, alu_cin));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 8'(busy), 8'h0);
    check({tag, "_done"}, 8'(done), 8'h0);
    check({tag, "_pass"}, 8'(pass), 8'h0);
    check({tag, "_err"}, 8'(err_count), 8'h0);
    check({tag, "_first"}, 8'(first_err_op), 8'h0);
    check({tag, "_s"}, 8'(alu_s), 8'h0);
    check({tag, "_a"}, 8'(alu_a), 8'h0);
    check({tag, "_b"}, 8'(alu_b), 8'h0);
    check({tag, "_cin"}, 8'(alu_cin), 8'h0);
  endtask

  // Full sweep: push expectations at start, pop per op and at done.
  task automatic run_sweep(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic c, input int mode, input logic [3:0] ey [8],
                           input summary_t es);
    summary_t s;
    fault_mode = mode;
    for (int i = 0; i < 8; i++) y_q.push_back(ey[i]);
    sum_q.push_back(es);
    @(negedge clk);
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a_in = ~a; b_in = ~b; cin_in = ~c;
    for (int k = 0; k < 8; k++) begin
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_op_s"}, 8'(alu_s), 8'(k));
      check({tag, "_op_a"}, 8'(alu_a), 8'(a));
      check({tag, "_op_b"}, 8'(alu_b), 8'(b));
      check({tag, "_op_cin"}, 8'(alu_cin), 8'(c));
      check({tag, "_op_busy"}, 8'(busy), 8'h1);
      check({tag, "_op_done"}, 8'(done), 8'h0);
      check({tag, "_op_y"}, 8'(alu_y), 8'(y_q.pop_front()));
      if (k == 4) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    s = sum_q.pop_front();
    check({tag, "_done"}, 8'(done), 8'h1);
    check({tag, "_busy_end"}, 8'(busy), 8'h0);
    check({tag, "_pass"}, 8'(pass), 8'(s.pass));
    check({tag, "_err"}, 8'(err_count), 8'(s.err_count));
    check({tag, "_first"}, 8'(first_err_op), 8'(s.first_err_op));
    repeat (2) @(posedge clk);
    #1 check({tag, "_done_hold"}, 8'(done), 8'h1);
  endtask

  task automatic check_log(input string tag, input logic [3:0] ey [8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      log_sel = 3'(i);
      #1;
`ifdef ALU_CHECK_LOG_EN
      check({tag, "_log"}, 8'(log_y), 8'(ey[i]));
`else
      check({tag, "_log_off"}, 8'(log_y), 8'(ey[i] & 4'h0));
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ey1 [8];
    logic [3:0] ey [8];
    ey1 = '{4'hE, 4'h9, 4'hA, 4'h3, 4'h2, 4'hB, 4'hC, 4'h9};
    rst_n = 1'b0; start = 1'b0; a_in = 4'h0; b_in = 4'h0; cin_in = 1'b0; log_sel = 3'd0;
    #12;
    check_all_zero("reset");
    check("reset_log", 8'(log_y), 8'h0);
    @(negedge clk) rst_n = 1'b1;

    run_sweep("s1", 4'h3, 4'hA, 1'b1, 0, ey1, '{pass: 1'b1, err_count: 4'd0, first_err_op: 3'd0});
    check_log("s1", ey1);

    for (int i = 0; i < 8; i++) ey[i] = inject(1, 3'(i), ey1[i]);
    run_sweep("s2", 4'h3, 4'hA, 1'b1, 1, ey, '{pass: 1'b0, err_count: 4'd1, first_err_op: 3'd5});

    for (int i = 0; i < 8; i++) ey[i] = inject(2, 3'(i), ey1[i]);
    run_sweep("s3", 4'h3, 4'hA, 1'b1, 2, ey, '{pass: 1'b0, err_count: 4'd2, first_err_op: 3'd2});

    for (int i = 0; i < 8; i++) ey[i] = gold(3'(i), 4'hF, 4'hF, 1'b1);
    run_sweep("s4", 4'hF, 4'hF, 1'b1, 0, ey, '{pass: 1'b1, err_count: 4'd0, first_err_op: 3'd0});

    // Abort a sweep with reset partway through, then rerun cleanly.
    fault_mode = 1;
    @(negedge clk);
    a_in = 4'h3; b_in = 4'hA; cin_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("s5_rst");
    @(negedge clk) rst_n = 1'b1;
    run_sweep("s5", 4'h3, 4'hA, 1'b1, 0, ey1, '{pass: 1'b1, err_count: 4'd0, first_err_op: 3'd0});
    check_log("s5", ey1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
